// File: rtl/board_engine.sv
// Match-3 board engine: 8x8 board of 3-bit colours with swap, match check, clear and gravity refill.
// Optional score accumulator enabled by defining BOARD_ENGINE_SCORE_EN.
module board_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_row,
    input  logic [2:0]  req_col,
    input  logic [1:0]  req_dir,
    output logic        req_ready,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [2:0]  wr_col,
    input  logic [2:0]  wr_color,
    input  logic [2:0]  rd_row,
    input  logic [2:0]  rd_col,
    output logic [2:0]  rd_color,
    output logic        busy,
    output logic        done,
    output logic        done_ok,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_CHECK,
        S_CLEAR,
        S_DROP,
        S_UNSWAP
    } state_t;

    localparam logic [2:0] EMPTY = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  board_q [8][8];
    logic [2:0]  board_d [8][8];
    logic [23:0] lfsr_q, lfsr_d;
    logic [2:0]  r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
    logic        first_q, first_d;
    logic        done_q, done_d;
    logic        done_ok_q, done_ok_d;

    logic [7:0][7:0] mark;
    logic            any_mark;
    logic            drop_empty;
    logic            drop_found;
    logic [2:0]      drop_low;
    logic [2:0]      nb_row, nb_col;
    logic            off_edge;

    function automatic logic [2:0] gen_color(input logic [2:0] v);
        return (v < 3'd6) ? v : v - 3'd6;
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign done_ok   = done_ok_q;
    assign rd_color  = board_q[rd_row][rd_col];

    assign lfsr_d = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};

    always_comb begin
        nb_row   = req_row;
        nb_col   = req_col;
        off_edge = 1'b0;
        case (req_dir)
            2'd0: begin off_edge = (req_col == 3'd7); nb_col = req_col + 3'd1; end
            2'd1: begin off_edge = (req_row == 3'd7); nb_row = req_row + 3'd1; end
            2'd2: begin off_edge = (req_col == 3'd0); nb_col = req_col - 3'd1; end
            default: begin off_edge = (req_row == 3'd0); nb_row = req_row - 3'd1; end
        endcase
    end

    // A cell is marked if any 3-wide window through it holds one non-empty colour.
    always_comb begin
        mark = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (board_q[r][c] != EMPTY && board_q[r][c] == board_q[r][c+1]
                    && board_q[r][c] == board_q[r][c+2]) begin
                    mark[r][c]   = 1'b1;
                    mark[r][c+1] = 1'b1;
                    mark[r][c+2] = 1'b1;
                end
            end
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (board_q[r][c] != EMPTY && board_q[r][c] == board_q[r+1][c]
                    && board_q[r][c] == board_q[r+2][c]) begin
                    mark[r][c]   = 1'b1;
                    mark[r+1][c] = 1'b1;
                    mark[r+2][c] = 1'b1;
                end
            end
        end
        any_mark = |mark;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        board_d    = board_q;
        drop_found = 1'b0;
        drop_low   = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (wr_en && wr_color < 3'd6) board_d[wr_row][wr_col] = wr_color;
            end
            S_SWAP, S_UNSWAP: begin
                board_d[r1_q][c1_q] = board_q[r2_q][c2_q];
                board_d[r2_q][c2_q] = board_q[r1_q][c1_q];
            end
            S_CLEAR: begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        if (mark[r][c]) board_d[r][c] = EMPTY;
            end
            S_DROP: begin
                for (int c = 0; c < 8; c++) begin
                    drop_found = 1'b0;
                    drop_low   = 3'd0;
                    for (int r = 0; r < 8; r++) begin
                        if (board_q[r][c] == EMPTY) begin
                            drop_found = 1'b1;
                            drop_low   = 3'(r);
                        end
                    end
                    // Cells above the lowest hole fall one row; row 0 takes a fresh colour.
                    if (drop_found) begin
                        for (int r = 1; r < 8; r++)
                            if (r <= int'(drop_low)) board_d[r][c] = board_q[r-1][c];
                        board_d[0][c] = gen_color(lfsr_q[3*c +: 3]);
                    end
                end
            end
            default: ;
        endcase
        drop_empty = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (board_d[r][c] == EMPTY) drop_empty = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        r1_d      = r1_q;
        c1_d      = c1_q;
        r2_d      = r2_q;
        c2_d      = c2_q;
        first_d   = first_q;
        done_d    = 1'b0;
        done_ok_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!wr_en && req_valid) begin
                    if (off_edge) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_SWAP;
                        r1_d    = req_row;
                        c1_d    = req_col;
                        r2_d    = nb_row;
                        c2_d    = nb_col;
                        first_d = 1'b1;
                    end
                end
            end
            S_SWAP:  state_d = S_CHECK;
            S_CHECK: begin
                if (any_mark) begin
                    state_d = S_CLEAR;
                    first_d = 1'b0;
                end else if (first_q) begin
                    state_d = S_UNSWAP;
                end else begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    done_ok_d = 1'b1;
                end
            end
            S_CLEAR: state_d = S_DROP;
            S_DROP:  if (!drop_empty) state_d = S_CHECK;
            S_UNSWAP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the board is held in flops, not RAM, because reset must load every cell at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 24'h5A5A5A;
            r1_q      <= 3'd0;
            c1_q      <= 3'd0;
            r2_q      <= 3'd0;
            c2_q      <= 3'd0;
            first_q   <= 1'b0;
            done_q    <= 1'b0;
            done_ok_q <= 1'b0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    board_q[r][c] <= 3'((8 * r + c) % 6);
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            r1_q      <= r1_d;
            c1_q      <= c1_d;
            r2_q      <= r2_d;
            c2_q      <= c2_d;
            first_q   <= first_d;
            done_q    <= done_d;
            done_ok_q <= done_ok_d;
            board_q   <= board_d;
        end
    end

`ifdef BOARD_ENGINE_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;

    always_comb begin
        score_sum = {1'b0, score_q} + 17'($countones(mark));
        score_d   = score_q;
        if (state_q == S_CLEAR) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) score_q <= 16'd0;
        else     score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: directed scenarios plus random writes/moves against
// a cell-array reference model that replays the swap/match/clear/refill rules cycle by cycle.
module tb_board_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_row, req_col;
    logic [1:0]  req_dir;
    logic        req_ready;
    logic        wr_en;
    logic [2:0]  wr_row, wr_col, wr_color;
    logic [2:0]  rd_row, rd_col;
    logic [2:0]  rd_color;
    logic        busy, done, done_ok;
    logic [15:0] score;

    always #5 clk = ~clk;

    board_engine dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_color  (wr_color),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_color  (rd_color),
        .busy      (busy),
        .done      (done),
        .done_ok   (done_ok),
        .score     (score)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_board [8][8];
    bit          m_mark  [8][8];
    int          m_score;
    logic [23:0] m_lfsr;

    function automatic logic [23:0] lfsr_adv(input logic [23:0] l);
        return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    endfunction

    // Reference LFSR, free-running alongside the design from the same reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 24'h5A5A5A;
        else     m_lfsr <= lfsr_adv(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gen(input logic [23:0] l, input int c);
        int v;
        v = int'((l >> (3 * c)) & 24'h7);
        return (v < 6) ? v : v - 6;
    endfunction

    function automatic int exp_score();
`ifdef BOARD_ENGINE_SCORE_EN
        return m_score;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_board[r][c] = (8 * r + c) % 6;
        m_score = 0;
    endtask

    // Run-length scan of every row and column; returns the number of marked cells.
    function automatic int find_runs();
        int cnt, len, v, i;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_mark[r][c] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            i = 0;
            while (i < 8) begin
                v = m_board[r][i];
                len = 1;
                while (i + len < 8 && m_board[r][i+len] == v) len++;
                if (v != 7 && len >= 3)
                    for (int k = 0; k < len; k++) m_mark[r][i+k] = 1'b1;
                i += len;
            end
        end
        for (int c = 0; c < 8; c++) begin
            i = 0;
            while (i < 8) begin
                v = m_board[i][c];
                len = 1;
                while (i + len < 8 && m_board[i+len][c] == v) len++;
                if (v != 7 && len >= 3)
                    for (int k = 0; k < len; k++) m_mark[i+k][c] = 1'b1;
                i += len;
            end
        end
        cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (m_mark[r][c]) cnt++;
        return cnt;
    endfunction

    function automatic bit any_empty();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (m_board[r][c] == 7) return 1'b1;
        return 1'b0;
    endfunction

    task automatic swap_cells(input int r, input int c, input int r2, input int c2);
        int t;
        t = m_board[r][c];
        m_board[r][c] = m_board[r2][c2];
        m_board[r2][c2] = t;
    endtask

    // Replays one move from the LFSR value of the accept cycle; lat is accept-to-done cycles.
    task automatic model_move(input int r, input int c, input int d, input logic [23:0] l_in,
                              output int lat, output bit ok);
        int r2, c2, n, cnt, e;
        logic [23:0] l;
        bit first;
        r2 = r;
        c2 = c;
        case (d)
            0: c2 = c + 1;
            1: r2 = r + 1;
            2: c2 = c - 1;
            default: r2 = r - 1;
        endcase
        lat = -1;
        ok  = 1'b0;
        if (r2 < 0 || r2 > 7 || c2 < 0 || c2 > 7) begin
            lat = 1;
            return;
        end
        l = lfsr_adv(l_in);
        n = 1;
        swap_cells(r, c, r2, c2);
        first = 1'b1;
        while (n < 3000) begin
            n++;
            l = lfsr_adv(l);
            cnt = find_runs();
            if (cnt == 0) begin
                if (first) begin
                    swap_cells(r, c, r2, c2);
                    lat = n + 2;
                end else begin
                    lat = n + 1;
                    ok  = 1'b1;
                end
                return;
            end
            first = 1'b0;
            n++;
            l = lfsr_adv(l);
            for (int rr = 0; rr < 8; rr++)
                for (int cc = 0; cc < 8; cc++)
                    if (m_mark[rr][cc]) m_board[rr][cc] = 7;
            m_score = (m_score + cnt > 65535) ? 65535 : m_score + cnt;
            while (any_empty() && n < 3000) begin
                n++;
                l = lfsr_adv(l);
                for (int cc = 0; cc < 8; cc++) begin
                    e = -1;
                    for (int rr = 0; rr < 8; rr++)
                        if (m_board[rr][cc] == 7) e = rr;
                    if (e >= 0) begin
                        for (int rr = e; rr > 0; rr--) m_board[rr][cc] = m_board[rr-1][cc];
                        m_board[0][cc] = gen(l, cc);
                    end
                end
            end
        end
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        v = int'(rd_color);
    endtask

    task automatic read_board(input string tag);
        logic [23:0] got, exp;
        int v, bad;
        bad = 0;
        for (int r = 0; r < 8; r++) begin
            got = '0;
            exp = '0;
            for (int c = 0; c < 8; c++) begin
                read_cell(r, c, v);
                if (v >= 6) bad++;
                got[3*c +: 3] = 3'(v);
                exp[3*c +: 3] = 3'(m_board[r][c]);
            end
            check($sformatf("%s_row%0d", tag, r), {8'd0, got}, {8'd0, exp});
        end
        check({tag, "_no_color67"}, bad, 0);
        @(negedge clk);
    endtask

    task automatic do_write(input int r, input int c, input int col);
        wr_en    = 1'b1;
        wr_row   = 3'(r);
        wr_col   = 3'(c);
        wr_color = 3'(col);
        @(negedge clk);
        wr_en = 1'b0;
        if (col < 6) m_board[r][c] = col;
    endtask

    task automatic do_move(input int r, input int c, input int d, input string tag,
                           output int lat_o, output bit ok_o);
        logic [23:0] l0;
        int exp_lat, n, idle_cnt;
        bit exp_ok;
        req_valid = 1'b1;
        req_row   = 3'(r);
        req_col   = 3'(c);
        req_dir   = 2'(d);
        check({tag, "_ready"}, req_ready, 1);
        l0 = m_lfsr;
        model_move(r, c, d, l0, exp_lat, exp_ok);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        idle_cnt = 0;
        while (!done && n < 3000) begin
            if (!busy) idle_cnt++;
            if (n < exp_lat) begin
                req_valid = 1'($urandom);
                req_row   = 3'($urandom);
                req_col   = 3'($urandom);
                req_dir   = 2'($urandom);
                wr_en     = 1'($urandom);
                wr_row    = 3'($urandom);
                wr_col    = 3'($urandom);
                wr_color  = 3'($urandom);
            end
            @(negedge clk);
            req_valid = 1'b0;
            wr_en     = 1'b0;
            n++;
        end
        lat_o = n;
        ok_o  = done_ok;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_done_ok"}, done_ok, exp_ok);
        check({tag, "_busy_held"}, idle_cnt, 0);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_score"}, score, exp_score());
        read_board(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, v, bad;
        bit ok;
        rst = 1'b1;
        req_valid = 1'b0;
        req_row = '0; req_col = '0; req_dir = '0;
        wr_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_color = '0;
        rd_row = '0; rd_col = '0;
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;

        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_score", score, 0);
        read_cell(0, 0, v); check("reset_cell00", v, 0);
        read_cell(0, 7, v); check("reset_cell07", v, 1);
        read_cell(7, 0, v); check("reset_cell70", v, 2);
        read_cell(7, 7, v); check("reset_cell77", v, 3);
        read_board("reset");

        do_move(0, 0, 3, "off_edge", lat, ok);
        check("off_edge_lat1", lat, 1);
        check("off_edge_rejected", ok, 0);

        do_move(0, 0, 0, "revert", lat, ok);
        check("revert_lat4", lat, 4);
        check("revert_rejected", ok, 0);

        do_write(0, 0, 6);
        do_write(0, 1, 7);
        read_board("ignored_write");

        do_write(7, 0, 3);
        do_write(7, 1, 3);
        do_write(7, 3, 3);
        do_move(7, 2, 0, "match", lat, ok);
        check("match_kept", ok, 1);
`ifdef BOARD_ENGINE_SCORE_EN
        check("match_score_ge3", score >= 16'd3, 1);
`endif

        // Write and request in the same idle cycle: write wins, request dropped.
        wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd3; wr_color = 3'd5;
        req_valid = 1'b1; req_row = 3'd0; req_col = 3'd0; req_dir = 2'd0;
        @(negedge clk);
        wr_en = 1'b0;
        req_valid = 1'b0;
        m_board[3][3] = 5;
        check("wr_prio_busy", busy, 0);
        @(negedge clk);
        check("wr_prio_busy2", busy, 0);
        check("wr_prio_no_done", done, 0);
        read_board("wr_prio");

        // Reset mid-DROP: accept a matching move, then assert reset four cycles later.
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_write(7, 0, 3);
        do_write(7, 1, 3);
        do_write(7, 3, 3);
        req_valid = 1'b1; req_row = 3'd7; req_col = 3'd2; req_dir = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_busy_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_drop_busy", busy, 0);
        check("rst_drop_done", done, 0);
        check("rst_drop_score", score, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        read_board("rst_drop");

        for (int it = 0; it < 120; it++) begin
            repeat ($urandom_range(0, 5)) begin
                v = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, 7);
                do_write($urandom_range(0, 7), $urandom_range(0, 7), v);
            end
            do_move($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                    $sformatf("rnd%0d", it), lat, ok);
        end

        bad = 0;
        check("final_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_engine.md
BOARD_ENGINE -- requirements
Module: board_engine

Interface
REQ-001 SHALL have parameters: none; the board is fixed at 8x8 cells with 3-bit colour codes 0-5, and code 7 means empty (internal only).
REQ-002 SHALL have the following ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  swap request
- req_row  in  3  selected row; row 0 is the top row
- req_col  in  3  selected column
- req_dir  in  2  0=right, 1=down, 2=left, 3=up
- req_ready  out  1  high only in IDLE
- wr_en  in  1  direct cell write; honoured only in IDLE
- wr_row  in  3  write row
- wr_col  in  3  write column
- wr_color  in  3  write colour; values 6 and 7 are ignored
- rd_row  in  3  display read row
- rd_col  in  3  display read column
- rd_color  out  3  combinational colour of cell (rd_row, rd_col)
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle completion pulse
- done_ok  out  1  qualifies done: 1=move kept, 0=rejected/reverted
- score  out  16  count of cleared cells

Function
REQ-003 SHALL implement FSM states IDLE, SWAP, CHECK, CLEAR, DROP and UNSWAP.
REQ-004 SHALL accept a request on req_valid&req_ready; request inputs during busy are ignored and SHALL NOT be queued.
REQ-005 SHALL treat a target cell off the board edge as rejected: no board change, and done=1, done_ok=0 the cycle after acceptance.
REQ-006 SHALL, in SWAP (1 cycle), exchange the selected cell with its neighbour; equal colours still proceed.
REQ-007 SHALL, in CHECK (1 cycle), mark every cell lying in a horizontal or vertical run of at least 3 equal non-empty colours.
REQ-008 SHALL, when CHECK finds no marks on the first check after SWAP, go to UNSWAP (1 cycle, restores both cells), then IDLE with done_ok=0.
REQ-009 SHALL, when a cascade CHECK finds no marks, go to IDLE with done_ok=1.
REQ-010 SHALL, when marks exist, enter CLEAR (1 cycle), set all marked cells to empty, and add the marked-cell count to score, saturating at 16'hFFFF.
REQ-011 SHALL, per DROP cycle and per column containing an empty cell, shift all cells above that column's lowest empty cell down one row, and load row 0 with that column's generated colour.
REQ-012 SHALL repeat DROP until no empty cell remains, then return to CHECK (cascade).
REQ-013 SHALL generate colours from a 24-bit Fibonacci LFSR that advances every cycle: shift left, new bit = l[23]^l[22]^l[21]^l[16].
REQ-014 SHALL derive column c's colour from v = l[3c+2:3c], giving v if v<6 and v-6 otherwise.
REQ-015 SHALL assert done for exactly one cycle, in the first IDLE cycle after the operation, with done_ok valid only in that cycle.
REQ-016 SHALL give wr_en priority over req_valid when both are asserted in the same IDLE cycle; the write takes effect and the request is not accepted.
REQ-017 SHALL never present colour 6 or 7 on rd_color while IDLE.

Reset
REQ-018 SHALL, on rst (asynchronous, any state), load cell[r][c] = (8r+c) mod 6 (a board with no runs).
REQ-019 SHALL, on rst, set score=0, LFSR=24'h5A5A5A, state=IDLE, done=0 and done_ok=0.

Configuration
REQ-020 SHALL, with BOARD_ENGINE_SCORE_EN defined, implement the score accumulator as specified.
REQ-021 SHALL, without BOARD_ENGINE_SCORE_EN, tie score to 0 and omit the accumulator; all other behaviour is unchanged.

Verification
REQ-022 Bench SHALL cover: reset, then read all 64 cells -> cell(0,0)=0, (0,7)=1, (7,0)=2, (7,7)=3; score=0; busy=0.
REQ-023 Bench SHALL cover: request row 0, col 0, dir 3 (up) -> done=1, done_ok=0 the next cycle; board unchanged.
REQ-024 Bench SHALL cover: request row 0, col 0, dir 0 on the reset board -> SWAP, CHECK, UNSWAP, done_ok=0 four cycles after acceptance; board unchanged.
REQ-025 Bench SHALL cover: write (7,0)=3, (7,1)=3 and (7,3)=3, then request row 7, col 2, dir 0 -> done_ok=1; score>=3; no cell reads 6 or 7.
REQ-026 Bench SHALL cover: assert rst during DROP -> busy=0 immediately; reset board pattern and score=0 restored.
REQ-027 Bench SHALL cover: wr_en and req_valid in the same IDLE cycle -> write applied; request not accepted; busy stays 0.
